// File: rtl/aqua_change_dispenser.sv
// aqua_change_dispenser: coin hopper sequencer for vending change; AQUA_HOPPER_TIMEOUT_EN adds a hopper ack timeout with sticky err
module aqua_change_dispenser #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       change_valid,
    input  logic [3:0] change,
    input  logic       hopper_ack,
    output logic       coin10,
    output logic       coin5,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] remaining
);
    typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;
    typedef logic [$clog2(TIMEOUT_CYCLES + 1)-1:0] tcnt_t;
    state_t     state, state_n;
    logic [3:0] rem_n, dec;
    logic       legal, accept, err_n, timeout;
    always_comb begin
        legal   = change == 4'd0 || change == 4'd5 || change == 4'd10 || change == 4'd15;
        accept  = state == IDLE && change_valid && legal;
        dec     = remaining >= 4'd10 ? remaining - 4'd10 : remaining >= 4'd5 ? remaining - 4'd5 : 4'd0;
        state_n = state;
        rem_n   = remaining;
        unique case (state)
            IDLE: if (accept) begin
                rem_n   = change;
                state_n = change == 4'd0 ? DONE : REQ;
            end
            REQ: if (hopper_ack) begin
                rem_n   = dec;
                state_n = dec != 4'd0 ? GAP : DONE;
            end else if (timeout) begin
                state_n = IDLE;
            end
            GAP:  state_n = REQ;
            DONE: state_n = IDLE;
        endcase
    end
`ifdef AQUA_HOPPER_TIMEOUT_EN
    tcnt_t tcnt;
    logic  sticky;
    assign timeout = state == REQ && !hopper_ack && tcnt == tcnt_t'(TIMEOUT_CYCLES - 1);
    assign err_n   = (change_valid && !accept) || timeout || (sticky && !accept);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt   <= '0;
            sticky <= 1'b0;
        end else begin
            tcnt   <= state == REQ && state_n == REQ ? tcnt + 1'b1 : '0;
            sticky <= timeout || (sticky && !accept);
        end
    end
`else
    assign timeout = 1'b0;
    assign err_n   = change_valid && !accept;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= 4'd0;
            coin10    <= 1'b0;
            coin5     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= rem_n;
            coin10    <= state_n == REQ && rem_n >= 4'd10;
            coin5     <= state_n == REQ && rem_n < 4'd10;
            busy      <= state_n != IDLE;
            done      <= state_n == DONE;
            err       <= err_n;
        end
    end
endmodule

// File: tb/tb_aqua_change_dispenser.sv
// tb_aqua_change_dispenser: directed checks of the change dispenser sequencing, errors and reset
module tb_aqua_change_dispenser;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       change_valid = 1'b0;
    logic [3:0] change = 4'd0;
    logic       hopper_ack = 1'b0;
    logic       coin10, coin5, busy, done, err;
    logic [3:0] remaining;
    int         checks = 0;
    int         errors = 0;

    aqua_change_dispenser dut (
        .clk(clk), .reset(reset), .change_valid(change_valid), .change(change),
        .hopper_ack(hopper_ack), .coin10(coin10), .coin5(coin5), .busy(busy),
        .done(done), .err(err), .remaining(remaining)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // packs {coin10, coin5, busy, done, err} for compact checks
    function automatic logic [7:0] outs();
        return {3'b0, coin10, coin5, busy, done, err};
    endfunction

    initial begin
        @(negedge clk);
        check("rst_outs", outs(), 8'h00);
        check("rst_rem", remaining, 8'd0);
        reset = 1'b1;
        tick();
        check("idle_after_rst", outs(), 8'h00);

        // 15: coin10, gap, coin5, done
        change_valid = 1'b1; change = 4'd15; tick();
        change_valid = 1'b0;
        check("r15_req10", outs(), 8'b10100);
        check("r15_rem15", remaining, 8'd15);
        tick();
        check("r15_hold10", outs(), 8'b10100);
        hopper_ack = 1'b1; tick(); hopper_ack = 1'b0;
        check("r15_gap", outs(), 8'b00100);
        check("r15_rem5", remaining, 8'd5);
        tick();
        check("r15_req5", outs(), 8'b01100);
        tick();
        hopper_ack = 1'b1; tick(); hopper_ack = 1'b0;
        check("r15_done", outs(), 8'b00110);
        check("r15_rem0", remaining, 8'd0);
        tick();
        check("r15_idle", outs(), 8'h00);

        // 10 with a change_valid while busy
        change_valid = 1'b1; change = 4'd10; tick();
        check("r10_req", outs(), 8'b10100);
        check("r10_rem", remaining, 8'd10);
        change = 4'd5; tick();
        change_valid = 1'b0;
        check("r10_busy_err", outs(), 8'b10101);
        check("r10_rem_kept", remaining, 8'd10);
        tick();
        check("r10_err_clear", outs(), 8'b10100);
        hopper_ack = 1'b1; tick(); hopper_ack = 1'b0;
        check("r10_done", outs(), 8'b00110);
        check("r10_rem0", remaining, 8'd0);
        tick();
        check("r10_idle", outs(), 8'h00);

        // zero change
        change_valid = 1'b1; change = 4'd0; tick();
        change_valid = 1'b0;
        check("r0_done", outs(), 8'b00110);
        tick();
        check("r0_idle", outs(), 8'h00);

        // illegal amount
        change_valid = 1'b1; change = 4'd7; tick();
        change_valid = 1'b0;
        check("r7_err", outs(), 8'b00001);
        check("r7_rem", remaining, 8'd0);
        tick();
        check("r7_err_pulse", outs(), 8'h00);

        // stray ack in IDLE
        hopper_ack = 1'b1; tick(); hopper_ack = 1'b0;
        check("idle_ack", outs(), 8'h00);

        // async reset mid-dispense
        change_valid = 1'b1; change = 4'd10; tick();
        change_valid = 1'b0;
        check("rst_pre", outs(), 8'b10100);
        #2 reset = 1'b0;
        #1;
        check("rst_async_outs", outs(), 8'h00);
        check("rst_async_rem", remaining, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("rst_no_resume", outs(), 8'h00);

        // 5 after reset
        change_valid = 1'b1; change = 4'd5; tick();
        change_valid = 1'b0;
        check("r5_req", outs(), 8'b01100);
        check("r5_rem", remaining, 8'd5);
`ifdef AQUA_HOPPER_TIMEOUT_EN
        tick(15);
        check("to_last_req", outs(), 8'b01100);
        tick();
        check("to_drop", outs(), 8'b00001);
        check("to_rem", remaining, 8'd5);
        tick(3);
        check("to_sticky", outs(), 8'b00001);
        change_valid = 1'b1; change = 4'd10; tick();
        change_valid = 1'b0;
        check("to_clear", outs(), 8'b10100);
        hopper_ack = 1'b1; tick(); hopper_ack = 1'b0;
        check("to_done", outs(), 8'b00110);
`else
        tick(20);
        check("no_to_wait", outs(), 8'b01100);
        hopper_ack = 1'b1; tick(); hopper_ack = 1'b0;
        check("r5_done", outs(), 8'b00110);
        check("r5_rem0", remaining, 8'd0);
`endif
        tick();
        check("final_idle", outs(), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
